// File: rtl/rs_dec_seq_16_8.sv
// Control sequencer for the RS(16,8) decoder: buffer addressing, stage start pulses, watchdog, output framing.
// Optional frame statistics counters are compiled in with `define RS_DEC_STATS_EN.
module rs_dec_seq_16_8 #(
    parameter int unsigned SYM_BW   = 8,
    parameter int unsigned N_NUM    = 16,
    parameter int unsigned R_NUM    = 8,
    parameter int unsigned STAGE_TO = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       syn_clr,
    output logic                       syn_en,
    input  logic                       syn_done,
    input  logic                       syn_zero,
    output logic                       kes_start,
    input  logic                       kes_done,
    input  logic [2:0]                 kes_deg,
    output logic                       chien_start,
    input  logic                       chien_done,
    input  logic [2:0]                 chien_cnt,
    output logic                       forney_start,
    input  logic                       forney_done,
    output logic                       buf_wr_en,
    output logic [$clog2(N_NUM)-1:0]   buf_wr_addr,
    output logic [$clog2(N_NUM)-1:0]   buf_rd_addr,
    output logic                       corr_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       out_fail,
    output logic                       busy
`ifdef RS_DEC_STATS_EN
    ,
    input  logic                       stat_clr,
    output logic [15:0]                stat_frames,
    output logic [15:0]                stat_corrected,
    output logic [15:0]                stat_failed
`endif
);

    localparam int unsigned      AW     = $clog2(N_NUM);
    localparam logic [AW-1:0]    LAST   = AW'(N_NUM - 1);
    localparam logic [2:0]       T_DEG  = 3'(R_NUM / 2);
    localparam logic [7:0]       WD_LIM = 8'(STAGE_TO);

    // Counter wrap must coincide with the last symbol, and the watchdog counter is 8 bits.
    if (SYM_BW == 0 || N_NUM < 2 || (N_NUM & (N_NUM - 1)) != 0 ||
        R_NUM / 2 > 7 || STAGE_TO == 0 || STAGE_TO > 255) begin : g_cfg_err
        $error("rs_dec_seq_16_8: unsupported parameter set");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        W_SYN,
        W_KES,
        W_CHN,
        W_FNY,
        OUT
    } state_t;

    state_t         state;
    logic [AW-1:0]  wr_cnt;
    logic [AW-1:0]  rd_cnt;
    logic [7:0]     wd_cnt;
    logic [2:0]     deg_q;
    logic           fail;
    logic           corr_q;
    logic           in_hs;
    logic           out_hs;
    logic           wd_hit;

    assign in_ready    = (state == IDLE) || (state == LOAD);
    assign in_hs       = in_valid & in_ready;
    assign syn_en      = in_hs;
    assign syn_clr     = in_hs & (state == IDLE);
    assign buf_wr_en   = in_hs;
    assign buf_wr_addr = wr_cnt;
    assign buf_rd_addr = rd_cnt;
    assign out_valid   = (state == OUT);
    assign out_hs      = out_valid & out_ready;
    assign out_last    = out_valid & (rd_cnt == LAST);
    assign corr_en     = corr_q;
    assign out_fail    = fail;
    assign busy        = (state != IDLE);
    assign wd_hit      = (wd_cnt == WD_LIM);

    // Watchdog counter defaults to zero so every stage-wait state starts counting from 0;
    // a done pulse is tested before the limit so it wins on the limit cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            wd_cnt       <= '0;
            deg_q        <= '0;
            fail         <= 1'b0;
            corr_q       <= 1'b0;
            kes_start    <= 1'b0;
            chien_start  <= 1'b0;
            forney_start <= 1'b0;
        end else begin
            kes_start    <= 1'b0;
            chien_start  <= 1'b0;
            forney_start <= 1'b0;
            wd_cnt       <= '0;
            unique case (state)
                IDLE: begin
                    if (in_hs) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_hs) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == LAST) state <= W_SYN;
                    end
                end
                W_SYN: begin
                    if (syn_done) begin
                        if (syn_zero) begin
                            state <= OUT;
                        end else begin
                            kes_start <= 1'b1;
                            state     <= W_KES;
                        end
                    end else if (wd_hit) begin
                        fail  <= 1'b1;
                        state <= OUT;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                W_KES: begin
                    if (kes_done) begin
                        deg_q <= kes_deg;
                        if (kes_deg == 3'd0 || kes_deg > T_DEG) begin
                            fail  <= 1'b1;
                            state <= OUT;
                        end else begin
                            chien_start <= 1'b1;
                            state       <= W_CHN;
                        end
                    end else if (wd_hit) begin
                        fail  <= 1'b1;
                        state <= OUT;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                W_CHN: begin
                    if (chien_done) begin
                        if (chien_cnt != deg_q) begin
                            fail  <= 1'b1;
                            state <= OUT;
                        end else begin
                            forney_start <= 1'b1;
                            state        <= W_FNY;
                        end
                    end else if (wd_hit) begin
                        fail  <= 1'b1;
                        state <= OUT;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                W_FNY: begin
                    if (forney_done) begin
                        corr_q <= 1'b1;
                        state  <= OUT;
                    end else if (wd_hit) begin
                        fail  <= 1'b1;
                        state <= OUT;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                OUT: begin
                    if (out_hs) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (rd_cnt == LAST) begin
                            wr_cnt <= '0;
                            fail   <= 1'b0;
                            corr_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RS_DEC_STATS_EN
    logic frame_end;
    assign frame_end = out_hs & out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_frames    <= '0;
            stat_corrected <= '0;
            stat_failed    <= '0;
        end else if (stat_clr) begin
            stat_frames    <= '0;
            stat_corrected <= '0;
            stat_failed    <= '0;
        end else if (frame_end) begin
            if (stat_frames != '1) stat_frames <= stat_frames + 16'd1;
            if (corr_en && stat_corrected != '1) stat_corrected <= stat_corrected + 16'd1;
            if (out_fail && stat_failed != '1) stat_failed <= stat_failed + 16'd1;
        end
    end
`endif

endmodule

// File: doc/rs_dec_seq_16_8.md
Name: rs_dec_seq_16_8

Overview:
Top-level sequencer for the RS(16,8) GF(256) t=4 decoder. Accepts one 16-symbol frame and writes it into the frame buffer while feeding the syndrome unit. It then starts, in order, key-equation solving (BM), Chien search and Forney. Finally it streams the buffered frame out with the correction-enable asserted. Control-only: symbol data never passes through this block; it drives buffer addresses and stage start pulses.

Parameters:
SYM_BW, 8, symbol width (address and count logic independent of it)
N_NUM, 16, symbols per codeword
R_NUM, 8, parity symbols; T = R_NUM/2 = 4
STAGE_TO, 255, watchdog limit in cycles per stage wait (max 255, counter 8 bit)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input symbol valid
in_ready  out  1  block can accept an input symbol
syn_clr  out  1  one-cycle pulse clearing syndrome accumulators
syn_en  out  1  symbol enable to syndrome unit (= in_valid & in_ready)
syn_done  in  1  pulse: syndromes final
syn_zero  in  1  sampled with syn_done: all syndromes zero
kes_start  out  1  pulse: start BM
kes_done  in  1  pulse: lambda/omega valid
kes_deg  in  3  degree of lambda, sampled with kes_done
chien_start  out  1  pulse: start Chien search
chien_done  in  1  pulse: roots found
chien_cnt  in  3  number of roots, sampled with chien_done
forney_start  out  1  pulse: start Forney
forney_done  in  1  pulse: error values valid
buf_wr_en  out  1  frame buffer write strobe
buf_wr_addr  out  4  write address
buf_rd_addr  out  4  read address (buffer read is combinational)
corr_en  out  1  apply Forney error values at buf_rd_addr on output
out_valid  out  1  output symbol valid
out_ready  in  1  downstream accepts symbol
out_last  out  1  marks symbol N_NUM-1
out_fail  out  1  frame uncorrectable; held valid for whole output frame
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE, all counters 0. All outputs 0 except in_ready=1 (IDLE accepts input). Reset mid-frame aborts all activity; no pulses emitted on release.
- States: IDLE, LOAD, W_SYN, W_KES, W_CHN, W_FNY, OUT.
- IDLE: in_ready=1. A handshake on the first symbol (in_valid & in_ready) enters LOAD. In the same cycle it asserts syn_clr and syn_en and writes address 0. syn_clr coincides with the first syn_en; the syndrome unit clears-then-accumulates.
- LOAD: in_ready=1. Each handshake writes buf_wr_addr = wr_cnt and increments wr_cnt. The handshake on symbol N_NUM-1 goes to W_SYN; in_ready drops next cycle. Gaps in in_valid are allowed.
- W_SYN: waits for syn_done.
  - syn_zero=1: go to OUT with corr_en=0 and out_fail=0.
  - otherwise: pulse kes_start on the transition cycle and go to W_KES.
- W_KES: on kes_done, latch kes_deg.
  - kes_deg=0 or >T: set fail and go to OUT.
  - otherwise: pulse chien_start and go to W_CHN.
- W_CHN: on chien_done, chien_cnt must equal the latched kes_deg.
  - mismatch: set fail and go to OUT.
  - match: pulse forney_start and go to W_FNY.
- W_FNY: on forney_done, go to OUT with corr_en=1.
- Watchdog: in each W_* state a counter is cleared on entry. When it reaches STAGE_TO with no done pulse, set fail and go to OUT. A done pulse arriving in the same cycle the limit is reached wins: normal transition, no fail.
- fail forces corr_en=0 (the frame is passed through uncorrected) and out_fail=1.
- Done pulses received in a state that does not await them are ignored.
- OUT:
  - out_valid=1 with buf_rd_addr = rd_cnt.
  - rd_cnt advances only on out_valid & out_ready; out_valid stays high under backpressure.
  - out_last = (rd_cnt==N_NUM-1).
  - The handshake on the last symbol returns to IDLE, clearing fail, corr_en and the counters.
- Latency: first out_valid one cycle after the forney_done cycle (or the syn_done cycle on the zero path).
- Only one frame is in flight: in_ready=0 from W_SYN through OUT.
- Counters are 4 bits: wr_cnt/rd_cnt wrap 15->0, and the FSM exit coincides with the wrap.

Optional Feature:
RS_DEC_STATS_EN:
- Defined: adds outputs stat_frames, stat_corrected, stat_failed, each 16 bits, saturating at 16'hFFFF. They increment on the out_last handshake:
  - stat_frames every frame;
  - stat_corrected when corr_en=1;
  - stat_failed when out_fail=1.
- Adds input stat_clr (1 bit, synchronous clear, priority over increment). All three counters reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Clean frame: 16 symbols back-to-back, syn_done with syn_zero=1 -> no kes_start; 16 output symbols, corr_en=0, out_fail=0, out_last on symbol 15.
- 2-error frame: syn_zero=0, kes_deg=2, chien_cnt=2, forney_done 4 cycles after forney_start -> each start pulse exactly 1 cycle; out_valid 1 cycle after forney_done; corr_en=1.
- Root mismatch: kes_deg=3, chien_cnt=2 -> no forney_start; OUT with out_fail=1, corr_en=0.
- Watchdog: kes_done withheld -> STAGE_TO=255 cycles after entering W_KES, OUT entered with out_fail=1. Repeat with kes_done on exactly the limit cycle -> chien_start and no fail.
- Backpressure and gaps: in_valid toggling 1/0 and out_ready low for 3 cycles at symbol 7 -> buf_wr_addr 0..15 with no skips; out_valid and buf_rd_addr=7 held steady; next frame accepted only after the out_last handshake.
- Reset mid-W_CHN, then rst_n released -> all outputs at reset values, in_ready=1; a later chien_done is ignored; a fresh frame decodes normally.
